pc16: RTL and testbench
=======================

Name: pc16

Overview:
- 16-bit program counter for the Hack-style CPU.
- Sits downstream of the ALU/A-register path: it consumes the jump target (A register value) and jump decision, and produces the instruction-memory address.
- Per cycle it does one of: clear, load, increment or hold.
- Adds a halt/run state machine and a sticky wrap flag so the CPU can be frozen and address overflow detected.

Parameters:
- WIDTH, 16, counter and address width in bits.
- RESET_ADDR, 16'h0000, value loaded on async reset and on synchronous clear.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear to RESET_ADDR (CPU reset pin).
- load  input  1  load jump target from `in`.
- inc  input  1  increment by one.
- in  input  WIDTH  jump target (A register).
- halt_req  input  1  request to freeze the counter.
- resume  input  1  request to leave HALT.
- out  output  WIDTH  current PC / instruction address.
- halted  output  1  high while in HALT state.
- wrap  output  1  sticky flag, set when an increment rolls 16'hFFFF to 16'h0000.

Behaviour:
- One clock, rst asynchronous active-high; all state updates on rising clk.
- rst asserted: out = RESET_ADDR, halted = 0, wrap = 0, state = RUN, immediately (no clock needed). Deassertion is synchronous to clk (external synchroniser). rst mid-operation overrides everything in the same instant.
- States: RUN, HALT.
- RUN -> HALT: on a clock edge with halt_req = 1. The PC update for that same edge still happens (halt takes effect from the next cycle).
- HALT -> RUN: on a clock edge with resume = 1 and halt_req = 0. If both are 1, stay in HALT.
- halted = 1 exactly when state = HALT (registered output, 1-cycle latency from halt_req).
- PC update priority, evaluated each edge: clr > halt freeze > load > inc > hold.
  - clr = 1: out <= RESET_ADDR and wrap <= 0, in any state. State is unchanged (clr in HALT keeps HALT).
  - In HALT without clr: out holds and load/inc are ignored.
  - In RUN, load = 1: out <= in. inc is ignored when load and inc are both 1.
  - In RUN, inc = 1 and load = 0: out <= out + 1, modulo 2^WIDTH.
    - If out was all-ones, out becomes 0 and wrap <= 1.
    - wrap stays 1 until rst or clr.
  - Otherwise out holds.
- Load of 16'hFFFF followed by inc wraps normally.
- No combinational path from any input to out, halted or wrap; all outputs are registered.
- Latency: any load/inc/clr is visible on out one clk edge later.

Decomposition:
- Package hack_pkg:
  - WORD_W = 16, RESET_ADDR = 16'h0000.
  - state encoding constants PC_RUN = 1'b0, PC_HALT = 1'b1.
- Sub-module inc16:
  - combinational out = a + 1 plus carry-out.
  - built as a half-adder chain from the existing Not/And/Xor gates.
  - carry-out drives the wrap-set logic.
- Next-value selection uses a priority chain of Mux16 instances.
- State and output registers live in pc16.

Test Plan:
1. Reset then count: rst pulse, then inc = 1 for 5 cycles -> out = 0,1,2,3,4,5; wrap = 0, halted = 0.
2. Load vs inc priority: out = 16'h0005; load = 1, inc = 1, in = 16'h1234 -> next out = 16'h1234; next cycle inc only -> 16'h1235.
3. Wrap: load in = 16'hFFFF, then inc -> out = 16'h0000 and wrap = 1. Further incs keep wrap = 1. clr -> out = 0, wrap = 0.
4. Halt/resume:
   - at out = 16'h0010, assert halt_req with inc = 1 -> out = 16'h0011, halted = 1 next cycle.
   - 3 more inc cycles leave out = 16'h0011.
   - resume = 1 with halt_req = 0 -> halted = 0, and the next inc gives 16'h0012.
   - resume = 1 with halt_req = 1 -> stays halted.
5. clr in HALT: halted, out = 16'h0042, clr = 1 -> out = 16'h0000, halted remains 1.
6. Async reset mid-operation: counting with inc, assert rst between clock edges -> out = 0, wrap = 0, halted = 0 before the next edge. After release, counting resumes from 0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared constants for the Hack-style CPU blocks: word width, reset address
// and the program-counter run/halt state encoding.
package hack_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_ADDR = 16'h0000;

  localparam logic [0:0] PC_RUN  = 1'b0;
  localparam logic [0:0] PC_HALT = 1'b1;

endpackage

// File: rtl/hack_gates.sv
// Primitive gates and the word-wide two-input multiplexer used to build the
// Hack datapath blocks.
module Not (
  input  logic in,
  output logic out
);
  assign out = ~in;
endmodule

module And (
  input  logic a,
  input  logic b,
  output logic out
);
  assign out = a & b;
endmodule

module Xor (
  input  logic a,
  input  logic b,
  output logic out
);
  assign out = a ^ b;
endmodule

// sel = 0 passes a, sel = 1 passes b.
module Mux16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] out
);
  assign out = sel ? b : a;
endmodule

// File: rtl/inc16.sv
// Incrementer built as a half-adder ripple chain; cout is high only when the
// all-ones input rolls over to zero.
module inc16 #(
  parameter int W = hack_pkg::WORD_W
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] out,
  output logic         cout
);

  logic [W:0] carry;

  // The constant +1 enters at bit 0, so that stage reduces to an inverter.
  Not u_not0 (.in(a[0]), .out(out[0]));
  assign carry[1] = a[0];

  for (genvar i = 1; i < W; i++) begin : g_ha
    Xor u_sum   (.a(a[i]), .b(carry[i]), .out(out[i]));
    And u_carry (.a(a[i]), .b(carry[i]), .out(carry[i+1]));
  end

  assign carry[0] = 1'b1;
  assign cout     = carry[W];

endmodule

// File: rtl/pc16.sv
// Hack program counter with clear/load/increment/hold, a run/halt freeze
// state machine and a sticky wrap flag for address overflow.
module pc16 #(
  parameter int               WIDTH      = hack_pkg::WORD_W,
  parameter logic [WIDTH-1:0] RESET_ADDR = hack_pkg::RESET_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] out,
  output logic             halted,
  output logic             wrap
);

  import hack_pkg::*;

  logic [0:0]       state;
  logic             run;
  logic             carry;
  logic             wrap_set;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] inc_or_hold;
  logic [WIDTH-1:0] load_sel;
  logic [WIDTH-1:0] run_sel;
  logic [WIDTH-1:0] pc_next;

  assign run    = (state == PC_RUN);
  assign halted = (state == PC_HALT);

  inc16 #(.W(WIDTH)) u_inc (.a(out), .out(pc_plus), .cout(carry));

  // Priority chain, lowest first: inc, then load, then halt freeze, then clr.
  Mux16 #(.W(WIDTH)) mux_inc  (.a(out),         .b(pc_plus),    .sel(inc),  .out(inc_or_hold));
  Mux16 #(.W(WIDTH)) mux_load (.a(inc_or_hold), .b(in),         .sel(load), .out(load_sel));
  Mux16 #(.W(WIDTH)) mux_run  (.a(out),         .b(load_sel),   .sel(run),  .out(run_sel));
  Mux16 #(.W(WIDTH)) mux_clr  (.a(run_sel),     .b(RESET_ADDR), .sel(clr),  .out(pc_next));

  assign wrap_set = ~clr & run & ~load & inc & carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= RESET_ADDR;
      wrap <= 1'b0;
    end else begin
      out <= pc_next;
      if (clr)
        wrap <= 1'b0;
      else if (wrap_set)
        wrap <= 1'b1;
    end
  end

  // A halt request wins over a simultaneous resume; clr never changes state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PC_RUN;
    end else begin
      case (state)
        PC_RUN:  if (halt_req) state <= PC_HALT;
        PC_HALT: if (resume && !halt_req) state <= PC_RUN;
        default: state <= PC_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc16.sv
// Scoreboard bench for pc16: a reference model predicts each edge's outputs,
// which are queued on drive and popped for comparison after the edge.
module tb_pc16;

  typedef struct packed {
    logic [15:0] pc;
    logic        halted;
    logic        wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic        inc = 1'b0;
  logic [15:0] in = 16'h0000;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [15:0] out;
  logic        halted;
  logic        wrap;

  int compared = 0;
  int mismatched = 0;

  exp_t        sb[$];
  logic [15:0] m_pc = 16'h0000;
  logic        m_halt = 1'b0;
  logic        m_wrap = 1'b0;

  pc16 dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .inc(inc), .in(in),
    .halt_req(halt_req), .resume(resume),
    .out(out), .halted(halted), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input exp_t e);
    checkOutput({tag, ".out"}, {16'h0, out}, {16'h0, e.pc});
    checkOutput({tag, ".halted"}, {31'h0, halted}, {31'h0, e.halted});
    checkOutput({tag, ".wrap"}, {31'h0, wrap}, {31'h0, e.wrap});
  endtask

  // Drives one cycle of inputs, predicts the post-edge outputs, then compares.
  task automatic applyStimulus(input string tag, input logic c, input logic l,
                               input logic i, input logic [15:0] d,
                               input logic h, input logic r);
    exp_t e;
    @(negedge clk);
    clr = c; load = l; inc = i; in = d; halt_req = h; resume = r;
    if (c) begin
      m_pc = 16'h0000;
      m_wrap = 1'b0;
    end else if (!m_halt) begin
      if (l) begin
        m_pc = d;
      end else if (i) begin
        if (m_pc == 16'hFFFF) m_wrap = 1'b1;
        m_pc = m_pc + 16'h0001;
      end
    end
    if (!m_halt) m_halt = h;
    else if (r && !h) m_halt = 1'b0;
    e.pc = m_pc; e.halted = m_halt; e.wrap = m_wrap;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkAll(tag, e);
    end
    clr = 1'b0; load = 1'b0; inc = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  initial begin
    exp_t e0;
    $display("[TB] pc16 bench start");
    #2;
    e0 = '0;
    checkAll("reset", e0);
    @(negedge clk);
    rst = 1'b0;

    // Reset then count
    for (int k = 0; k < 5; k++) applyStimulus("count", 0, 0, 1, 16'h0, 0, 0);
    checkOutput("count5", {16'h0, out}, 32'h0005);

    // Load beats inc
    applyStimulus("load_inc", 0, 1, 1, 16'h1234, 0, 0);
    checkOutput("load_pri", {16'h0, out}, 32'h1234);
    applyStimulus("inc_after_load", 0, 0, 1, 16'h0, 0, 0);
    checkOutput("inc_1235", {16'h0, out}, 32'h1235);

    // Wrap and sticky flag
    applyStimulus("load_ffff", 0, 1, 0, 16'hFFFF, 0, 0);
    applyStimulus("wrap_inc", 0, 0, 1, 16'h0, 0, 0);
    checkOutput("wrap_set", {31'h0, wrap}, 32'd1);
    applyStimulus("wrap_sticky1", 0, 0, 1, 16'h0, 0, 0);
    applyStimulus("wrap_sticky2", 0, 0, 1, 16'h0, 0, 0);
    applyStimulus("wrap_clr", 1, 0, 1, 16'h0, 0, 0);
    checkOutput("wrap_cleared", {31'h0, wrap}, 32'd0);

    // Halt / resume
    applyStimulus("load_0010", 0, 1, 0, 16'h0010, 0, 0);
    applyStimulus("halt_inc", 0, 0, 1, 16'h0, 1, 0);
    checkOutput("halt_pc", {16'h0, out}, 32'h0011);
    for (int k = 0; k < 3; k++) applyStimulus("halt_hold", 0, 0, 1, 16'h0, 0, 0);
    applyStimulus("halt_load_ign", 0, 1, 0, 16'hBEEF, 0, 0);
    applyStimulus("resume", 0, 0, 0, 16'h0, 0, 1);
    checkOutput("resumed", {31'h0, halted}, 32'd0);
    applyStimulus("post_resume_inc", 0, 0, 1, 16'h0, 0, 0);
    checkOutput("pc_0012", {16'h0, out}, 32'h0012);
    applyStimulus("halt_again", 0, 0, 0, 16'h0, 1, 0);
    applyStimulus("resume_and_halt", 0, 0, 0, 16'h0, 1, 1);
    checkOutput("still_halted", {31'h0, halted}, 32'd1);

    // clr while halted
    applyStimulus("resume2", 0, 0, 0, 16'h0, 0, 1);
    applyStimulus("load_0042", 0, 1, 0, 16'h0042, 0, 0);
    applyStimulus("halt_0042", 0, 0, 0, 16'h0, 1, 0);
    applyStimulus("clr_in_halt", 1, 0, 0, 16'h0, 0, 0);
    checkOutput("clr_halt_kept", {31'h0, halted}, 32'd1);
    applyStimulus("resume3", 0, 0, 0, 16'h0, 0, 1);

    // Random mix
    for (int k = 0; k < 60; k++) begin
      applyStimulus("random", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 1) == 1) ? 16'hFFFE : 16'($urandom),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
    end
    applyStimulus("wrap_prep_resume", 0, 0, 0, 16'h0, 0, 1);

    // Async reset mid-operation, between edges
    applyStimulus("pre_rst_load", 0, 1, 0, 16'hFFFF, 0, 0);
    applyStimulus("pre_rst_wrap", 0, 0, 1, 16'h0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    m_pc = 16'h0000; m_halt = 1'b0; m_wrap = 1'b0;
    e0 = '0;
    checkAll("async_rst", e0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post_rst1", 0, 0, 1, 16'h0, 0, 0);
    checkOutput("post_rst_pc", {16'h0, out}, 32'h0001);
    applyStimulus("post_rst2", 0, 0, 1, 16'h0, 0, 0);

    if (sb.size() != 0) checkOutput("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
